// File: rtl/rename_pkg.sv
// Shared types, sizes and helpers for the register-rename stage.
package rename_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 128;
  localparam int CKPT_DEPTH = 4;
  localparam int PREG_W     = $clog2(PHYS_REGS);
  localparam int AREG_W     = $clog2(ARCH_REGS);
  localparam int TAG_W      = $clog2(CKPT_DEPTH);
  localparam int CNT_W      = TAG_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef preg_t [ARCH_REGS-1:0] map_t;

  typedef struct packed {
    preg_t ps1;
    preg_t ps2;
    preg_t pd;
    preg_t pd_old;
    logic  rd_we;
    logic  is_branch;
    tag_t  br_tag;
  } ren_inst_t;

  // First physical register handed out after reset (0..31 hold the identity map).
  localparam preg_t SP_RESET = preg_t'(ARCH_REGS);
  localparam preg_t PREG_ONE = preg_t'(1'b1);
  localparam preg_t PREG_MAX = preg_t'(PHYS_REGS - 1);

  // Shadow read pointer advance; index 0 is never used, so 127 wraps to 1.
  function automatic preg_t sp_next(input preg_t sp);
    preg_t res;
    if (sp == PREG_MAX) begin
      res = PREG_ONE;
    end else begin
      res = sp + PREG_ONE;
    end
    return res;
  endfunction

  // Architectural register i maps to physical register i.
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REGS; i++) begin
      m[i] = preg_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_ckpt_store.sv
// Branch checkpoint store: CKPT_DEPTH snapshots of the map table and the
// shadow free-list pointer, managed as a circular queue (head = oldest).
module rename_ckpt_store
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  save,
  input  map_t  save_map,
  input  preg_t save_sp,
  input  logic  commit,
  input  logic  restore,
  input  tag_t  restore_tag,
  output tag_t  tail,
  output cnt_t  count,
  output map_t  restore_map,
  output preg_t restore_sp
);

  map_t  ckpt_map_r [CKPT_DEPTH];
  preg_t ckpt_sp_r  [CKPT_DEPTH];
  tag_t  head_r;
  tag_t  tail_r;
  cnt_t  count_r;

  logic  commit_ok_s;
  tag_t  head_nxt_s;
  tag_t  tail_nxt_s;
  tag_t  span_s;
  cnt_t  count_nxt_s;

  // Next head/tail/count; a restore keeps the restored entry and drops younger ones.
  always_comb begin
    commit_ok_s = commit && (count_r != cnt_t'(1'b0));
    head_nxt_s  = commit_ok_s ? (head_r + tag_t'(1'b1)) : head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    span_s      = restore_tag + tag_t'(1'b1) - head_nxt_s;
    if (restore) begin
      tail_nxt_s = restore_tag + tag_t'(1'b1);
      // Retained entries are never zero, so a zero modular span means a full queue.
      if (span_s == tag_t'(1'b0)) begin
        count_nxt_s = cnt_t'(CKPT_DEPTH);
      end else begin
        count_nxt_s = cnt_t'(span_s);
      end
    end else begin
      tail_nxt_s = save ? (tail_r + tag_t'(1'b1)) : tail_r;
      case ({save, commit_ok_s})
        2'b10:   count_nxt_s = count_r + cnt_t'(1'b1);
        2'b01:   count_nxt_s = count_r - cnt_t'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= tag_t'(1'b0);
      tail_r  <= tag_t'(1'b0);
      count_r <= cnt_t'(1'b0);
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Snapshot storage, written at the tail when a branch is renamed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CKPT_DEPTH; i++) begin
        ckpt_map_r[i] <= identity_map();
        ckpt_sp_r[i]  <= SP_RESET;
      end
    end else if (save) begin
      ckpt_map_r[tail_r] <= save_map;
      ckpt_sp_r[tail_r]  <= save_sp;
    end
  end

  assign tail        = tail_r;
  assign count       = count_r;
  assign restore_map = ckpt_map_r[restore_tag];
  assign restore_sp  = ckpt_sp_r[restore_tag];

endmodule

// File: rtl/rename_unit.sv
// Register-rename stage: map-table lookup, free-list allocation, branch
// checkpoints with mispredict restore, and a registered valid/ready output.
module rename_unit
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_rd_we,
  input  logic              dec_is_branch,
  input  logic              fl_empty,
  input  logic [PREG_W-1:0] fl_pd_new,
  output logic              fl_read_en,
  output logic [PREG_W-1:0] fl_re_ptr,
  output logic              ren_valid,
  input  logic              ren_ready,
  output logic [PREG_W-1:0] ren_ps1,
  output logic [PREG_W-1:0] ren_ps2,
  output logic [PREG_W-1:0] ren_pd,
  output logic [PREG_W-1:0] ren_pd_old,
  output logic              ren_rd_we,
  output logic              ren_is_branch,
  output logic [TAG_W-1:0]  ren_br_tag,
  input  logic              br_commit,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag
);

  map_t      map_r;
  preg_t     sp_r;
  ren_inst_t out_r;
  logic      valid_r;

  logic      alloc_s;
  logic      stall_s;
  logic      ready_s;
  logic      fire_s;
  map_t      map_upd_s;
  preg_t     sp_upd_s;
  ren_inst_t nxt_s;

  tag_t      ckpt_tail_s;
  cnt_t      ckpt_count_s;
  map_t      ckpt_map_s;
  preg_t     ckpt_sp_s;

  // Handshake: stall on an empty free list for a real destination or on a full checkpoint queue.
  always_comb begin
    alloc_s = dec_rd_we && (dec_rd != 5'd0);
    stall_s = (alloc_s && fl_empty) ||
              (dec_is_branch && (ckpt_count_s == cnt_t'(CKPT_DEPTH)));
    ready_s = !mispredict && !stall_s && (!valid_r || ren_ready);
    fire_s  = dec_valid && ready_s;
  end

  // Map table and shadow pointer as they stand after this instruction's own rd update.
  always_comb begin
    map_upd_s = map_r;
    sp_upd_s  = sp_r;
    if (fire_s && alloc_s) begin
      map_upd_s[dec_rd] = fl_pd_new;
      sp_upd_s          = sp_next(sp_r);
    end else begin
      map_upd_s = map_r;
      sp_upd_s  = sp_r;
    end
  end

  // Renamed instruction presented to the output register; sources read the pre-update map.
  always_comb begin
    nxt_s.ps1       = map_r[dec_rs1];
    nxt_s.ps2       = map_r[dec_rs2];
    nxt_s.pd        = alloc_s ? fl_pd_new : preg_t'(1'b0);
    nxt_s.pd_old    = alloc_s ? map_r[dec_rd] : preg_t'(1'b0);
    nxt_s.rd_we     = alloc_s;
    nxt_s.is_branch = dec_is_branch;
    nxt_s.br_tag    = dec_is_branch ? ckpt_tail_s : tag_t'(1'b0);
  end

  // Speculative map and shadow pointer; mispredict reloads them from the checkpoint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_r <= identity_map();
      sp_r  <= SP_RESET;
    end else if (mispredict) begin
      map_r <= ckpt_map_s;
      sp_r  <= ckpt_sp_s;
    end else begin
      map_r <= map_upd_s;
      sp_r  <= sp_upd_s;
    end
  end

  // Output stage: data held while stalled downstream, valid flushed by mispredict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      out_r   <= '0;
    end else begin
      if (mispredict) begin
        valid_r <= 1'b0;
      end else if (fire_s) begin
        valid_r <= 1'b1;
      end else if (ren_ready) begin
        valid_r <= 1'b0;
      end
      if (fire_s) begin
        out_r <= nxt_s;
      end
    end
  end

  rename_ckpt_store u_ckpt (
    .clk         (clk),
    .reset       (reset),
    .save        (fire_s && dec_is_branch),
    .save_map    (map_upd_s),
    .save_sp     (sp_upd_s),
    .commit      (br_commit),
    .restore     (mispredict),
    .restore_tag (mispredict_tag),
    .tail        (ckpt_tail_s),
    .count       (ckpt_count_s),
    .restore_map (ckpt_map_s),
    .restore_sp  (ckpt_sp_s)
  );

  assign dec_ready     = ready_s;
  assign fl_read_en    = fire_s && alloc_s;
  assign fl_re_ptr     = ckpt_sp_s;
  assign ren_valid     = valid_r;
  assign ren_ps1       = out_r.ps1;
  assign ren_ps2       = out_r.ps2;
  assign ren_pd        = out_r.pd;
  assign ren_pd_old    = out_r.pd_old;
  assign ren_rd_we     = out_r.rd_we;
  assign ren_is_branch = out_r.is_branch;
  assign ren_br_tag    = out_r.br_tag;

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage between decode and dispatch in the out-of-order core.
- Per instruction: reads the architectural-to-physical map table for rs1/rs2, takes a new physical destination from the free list, and updates the map.
- Keeps branch checkpoints of the map table and of the free-list read pointer, and restores both on mispredict.
- Issues one instruction per cycle through a registered valid/ready output stage.

Parameters:
ARCH_REGS, 32, number of architectural registers (x0 hardwired)
PHYS_REGS, 128, number of physical registers; PREG_W = $clog2(PHYS_REGS) = 7
CKPT_DEPTH, 4, number of in-flight branch checkpoints; TAG_W = $clog2(CKPT_DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
dec_valid  in  1  decoded instruction available
dec_ready  out  1  rename accepts the instruction this cycle
dec_rs1, dec_rs2, dec_rd  in  5 each  architectural register indices
dec_rd_we  in  1  instruction writes rd
dec_is_branch  in  1  instruction needs a checkpoint (branch/JALR)
fl_empty  in  1  free list has no entry
fl_pd_new  in  PREG_W  head of the free list (combinational)
fl_read_en  out  1  pop the free list this cycle
fl_re_ptr  out  PREG_W  restore pointer for the free list on mispredict
ren_valid  out  1  renamed instruction valid
ren_ready  in  1  dispatch accepts the instruction
ren_ps1, ren_ps2, ren_pd, ren_pd_old  out  PREG_W each  physical sources, new destination, previous mapping of rd
ren_rd_we, ren_is_branch  out  1 each  passed through; ren_rd_we is 0 when rd==0
ren_br_tag  out  TAG_W  checkpoint tag of a branch
br_commit  in  1  oldest checkpointed branch resolved correctly/committed
mispredict  in  1  flush; restore from mispredict_tag
mispredict_tag  in  TAG_W  checkpoint to restore

Behaviour:
- Reset (async): map[i]=i for i=0..31. Shadow read pointer sp=32. Checkpoint head=tail=count=0. ren_valid=0. All ren_* data outputs 0.
- alloc = dec_rd_we && dec_rd!=0.
- stall = (alloc && fl_empty) || (dec_is_branch && count==CKPT_DEPTH).
- dec_ready = !mispredict && !stall && (!ren_valid || ren_ready).
- fire = dec_valid && dec_ready.
- fl_read_en = fire && alloc. fl_re_ptr = ckpt_sp[mispredict_tag], combinational.
- On fire, registered into the output stage with 1-cycle latency:
  - ps1 = map[rs1], ps2 = map[rs2], pd_old = map[rd].
  - pd = fl_pd_new if alloc, else 0.
  - Map table and sp update at the same edge.
  - sp advances by one on each alloc and wraps 127 -> 1 (index 0 is never used), matching the free-list pointer.
- Rename of rd==0: no allocation; pd=0 and pd_old=0.
- Back-to-back dependent instructions read the updated map; no bypass is needed at one instruction per cycle.
- Output stage: ren_valid set on fire. It clears when ren_ready && !fire. Data is held stable while ren_valid && !ren_ready.
- Branch on fire:
  - ckpt_map[tail] gets the map *after* this instruction's own rd update.
  - ckpt_sp[tail] gets sp after its allocation.
  - ren_br_tag = tail; tail++ (mod CKPT_DEPTH); count++.
- br_commit: head++ and count--. Asserting it with count==0 is illegal; the design ignores it.
- mispredict, t = mispredict_tag:
  - map <= ckpt_map[t]; sp <= ckpt_sp[t].
  - tail <= t+1, discarding all younger checkpoints; count recomputed as (t+1-head) mod, with the mispredicting branch's checkpoint retained until its br_commit.
  - ren_valid <= 0; no fire that cycle.
- Simultaneous mispredict and br_commit: both apply, with head advanced. t must not equal the committing head entry; the bench asserts this.
- Simultaneous fire and br_commit: count unchanged when a branch fires.
- count==CKPT_DEPTH with a non-branch instruction: no stall.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Package rename_pkg: PREG_W, TAG_W, ARCH_REGS, PHYS_REGS, preg_t typedef, a renamed-instruction struct (ps1, ps2, pd, pd_old, rd_we, is_branch, br_tag), and a function sp_next() implementing the 127 -> 1 wrap.
- Sub-module rename_ckpt_store: holds CKPT_DEPTH map+sp snapshots and the head/tail/count logic.

Test Plan:
- Reset, then add x5,x1,x2: ps1=1, ps2=2, pd=32, pd_old=5, fl_read_en pulses once; next instruction with rd=x5 gives pd_old=32.
- Instruction with rd=x0 and rd_we=1: fl_read_en=0, pd=0, ren_rd_we=0; sp unchanged (next alloc gets 32 if it was first).
- Branch fires with sp=40 (tag 0), then 3 allocations (sp=43); mispredict tag 0: fl_re_ptr=40 in the same cycle; map restored (rd of the younger instructions reads pre-branch mapping); ren_valid=0.
- Fill 4 checkpoints; a 5th branch sees dec_ready=0 until br_commit; it then fires with ren_br_tag=0.
- Hold ren_ready=0 for 3 cycles: outputs stable, dec_ready=0, no fl_read_en. Separately, fl_empty=1 with alloc stalls, while a non-writing instruction passes.
- Drive sp to 127 via 95 allocations: the next alloc sets sp=1. Assert reset mid-stream between clock edges: ren_valid drops immediately and map becomes identity.
